// File: rtl/cic_decimate_comb_if.sv
// Stream bundle between the integrator, the decimating comb stage and the
// next stage. The upstream side drives en_i/data_i/valid_i and the comb
// stage drives data_o/valid_o.
//
// Handshake: there is no backpressure. A sample is accepted on every rising
// edge where en_i & valid_i is high. valid_o is a one-cycle strobe meaning
// that data_o was updated on the preceding edge.
interface cic_decimate_comb_if #(
    parameter int I_BW = 8,
    parameter int O_BW = 9
);
    logic                   en_i;
    logic signed [I_BW-1:0] data_i;
    logic                   valid_i;
    logic signed [O_BW-1:0] data_o;
    logic                   valid_o;

    // Upstream driver side
    modport master (
        output en_i, data_i, valid_i,
        input  data_o, valid_o
    );

    // Comb stage side
    modport slave (
        input  en_i, data_i, valid_i,
        output data_o, valid_o
    );
endinterface

// File: rtl/cic_decimate_comb.sv
// Decimating comb stage of a CIC decimator. It keeps the last sample of every
// group of R accepted integrator samples and computes y[k] = x[k] - x[k-M]
// on that decimated stream. The subtraction wraps modulo 2^O_BW on purpose,
// so integrator overflow cancels out.
module cic_decimate_comb #(
    parameter int I_BW = 8,
    parameter int O_BW = 9,
    parameter int R    = 4,
    parameter int M    = 1
) (
    input logic                clk_i,
    input logic                rst_n_i,
    cic_decimate_comb_if.slave bus
);
    localparam int CW = (R > 1) ? $clog2(R) : 1;

    logic [CW-1:0]          cnt;
    logic signed [O_BW-1:0] dl [M];
    logic signed [O_BW-1:0] data_q;
    logic                   valid_q;
    logic signed [O_BW-1:0] x;
    logic                   last;

    // Sign-extend the integrator sample to the output width before differencing.
    assign x    = O_BW'(bus.data_i);
    assign last = (cnt == CW'(R - 1));

    // Decimation counter, delay line and registered comb output.
    // en_i low clears everything and overrides a coincident take.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt     <= '0;
            for (int i = 0; i < M; i++) dl[i] <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else if (!bus.en_i) begin
            cnt     <= '0;
            for (int i = 0; i < M; i++) dl[i] <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (bus.valid_i) begin
                if (last) begin
                    cnt     <= '0;
                    data_q  <= x - dl[M-1];
                    dl[0]   <= x;
                    for (int i = 1; i < M; i++) dl[i] <= dl[i-1];
                    valid_q <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign bus.data_o  = data_q;
    assign bus.valid_o = valid_q;
endmodule

// File: tb/tb_cic_decimate_comb.sv
// Bench for cic_decimate_comb. Three instances share one stimulus stream:
//   a: I_BW=8 O_BW=9 R=4 M=1
//   b: I_BW=9 O_BW=9 R=1 M=1  (wrap-around case)
//   c: I_BW=8 O_BW=9 R=1 M=2  (differential delay case)
// A reference model built on accept counts and a history queue predicts all
// three; a directed table covers instance a, and short hand sequences cover
// instances b and c.
module tb_cic_decimate_comb;
    logic       clk;
    logic       rst_n;
    logic       en;
    logic       vin;
    logic [8:0] din9;

    int n_vec;
    int n_bad;

    cic_decimate_comb_if #(.I_BW(8), .O_BW(9)) if_a ();
    cic_decimate_comb_if #(.I_BW(9), .O_BW(9)) if_b ();
    cic_decimate_comb_if #(.I_BW(8), .O_BW(9)) if_c ();

    assign if_a.en_i    = en;
    assign if_a.valid_i = vin;
    assign if_a.data_i  = din9[7:0];
    assign if_b.en_i    = en;
    assign if_b.valid_i = vin;
    assign if_b.data_i  = din9;
    assign if_c.en_i    = en;
    assign if_c.valid_i = vin;
    assign if_c.data_i  = din9[7:0];

    cic_decimate_comb #(.I_BW(8), .O_BW(9), .R(4), .M(1)) dut_a (
        .clk_i(clk), .rst_n_i(rst_n), .bus(if_a.slave));
    cic_decimate_comb #(.I_BW(9), .O_BW(9), .R(1), .M(1)) dut_b (
        .clk_i(clk), .rst_n_i(rst_n), .bus(if_b.slave));
    cic_decimate_comb #(.I_BW(8), .O_BW(9), .R(1), .M(2)) dut_c (
        .clk_i(clk), .rst_n_i(rst_n), .bus(if_c.slave));

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: per instance, accepts since clear and the history of
    // taken samples. A take happens when the accept count is a multiple of R.
    int         r_t [3] = '{4, 1, 1};
    int         m_t [3] = '{1, 1, 2};
    int         acc [3];
    int         hist [3][$];
    bit         ev [3];
    logic [8:0] ed [3];

    function automatic void model_clear();
        for (int k = 0; k < 3; k++) begin
            acc[k] = 0;
            hist[k].delete();
            ev[k]  = 1'b0;
            ed[k]  = '0;
        end
    endfunction

    function automatic void model_edge(input bit e, input bit v, input logic [8:0] d);
        int x;
        int old;
        for (int k = 0; k < 3; k++) begin
            ev[k] = 1'b0;
            if (!e) begin
                acc[k] = 0;
                hist[k].delete();
                ed[k] = '0;
            end else if (v) begin
                acc[k]++;
                if (acc[k] % r_t[k] == 0) begin
                    x = (k == 1) ? int'($signed(d)) : int'($signed(d[7:0]));
                    old = (hist[k].size() >= m_t[k]) ? hist[k][hist[k].size() - m_t[k]] : 0;
                    ed[k] = 9'(x - old);
                    hist[k].push_back(x);
                    ev[k] = 1'b1;
                end
            end
        end
    endfunction

    // Scoreboard helpers
    task automatic chk(input string name, input logic [8:0] act, input logic [8:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("a.valid_o", {8'd0, if_a.valid_o}, {8'd0, ev[0]});
        chk("a.data_o",  if_a.data_o, ed[0]);
        chk("b.valid_o", {8'd0, if_b.valid_o}, {8'd0, ev[1]});
        chk("b.data_o",  if_b.data_o, ed[1]);
        chk("c.valid_o", {8'd0, if_c.valid_o}, {8'd0, ev[2]});
        chk("c.data_o",  if_c.data_o, ed[2]);
    endtask

    // Driver tasks: apply inputs, let one edge pass, check #1 after it
    task automatic step(input bit e, input bit v, input logic [8:0] d);
        en   = e;
        vin  = v;
        din9 = d;
        @(posedge clk);
        model_edge(e, v, d);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        #2;
        rst_n = 1'b0;
        model_clear();
        #1;
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
    endtask

    // Directed table for instance a (R=4, M=1)
    typedef struct {
        bit         en;
        bit         v;
        logic [8:0] d;
        bit         ev;
        logic [8:0] ed;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input bit e, input bit v, input int d, input bit xv, input int xd);
        vec_t t;
        t.en = e;
        t.v  = v;
        t.d  = 9'(d);
        t.ev = xv;
        t.ed = 9'(xd);
        tbl.push_back(t);
    endfunction

    initial begin
        n_vec = 0;
        n_bad = 0;
        rst_n = 1'b0;
        en    = 1'b0;
        vin   = 1'b0;
        din9  = '0;
        model_clear();

        // Continuous stream 1..12: takes at 4, 8, 12, each difference 4
        for (int i = 1; i <= 12; i++)
            add(1, 1, i, (i % 4 == 0), (i < 4) ? 0 : 4);
        add(0, 0, 0, 0, 0);
        // Gapped stream 1..8 with junk on the idle cycles
        for (int i = 1; i <= 8; i++) begin
            add(1, 1, i, (i % 4 == 0), (i < 4) ? 0 : 4);
            add(1, 0, 99, 0, (i < 4) ? 0 : 4);
        end
        // Clear drops the held output to 0
        add(0, 0, 0, 0, 0);
        // Three samples, clear with valid high, then a fresh group 5..8
        add(1, 1, 1, 0, 0);
        add(1, 1, 2, 0, 0);
        add(1, 1, 3, 0, 0);
        add(0, 1, 4, 0, 0);
        add(1, 1, 5, 0, 0);
        add(1, 1, 6, 0, 0);
        add(1, 1, 7, 0, 0);
        add(1, 1, 8, 1, 8);
        // Clear coinciding with what would be a take: clear wins
        add(1, 1, 9, 0, 8);
        add(1, 1, 10, 0, 8);
        add(1, 1, 11, 0, 8);
        add(0, 1, 12, 0, 0);
        add(1, 0, 0, 0, 0);

        // Reset, then idle with valid low
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) step(1, 0, 9'(i));

        foreach (tbl[i]) begin
            step(tbl[i].en, tbl[i].v, tbl[i].d);
            chk($sformatf("tbl[%0d].valid_o", i), {8'd0, if_a.valid_o}, {8'd0, tbl[i].ev});
            chk($sformatf("tbl[%0d].data_o", i), if_a.data_o, tbl[i].ed);
        end

        // Wrap-around on instance b: 255 then -256 gives 255 then +1
        step(0, 0, 0);
        step(1, 1, 9'h0ff);
        chk("wrap.valid0", {8'd0, if_b.valid_o}, 9'd1);
        chk("wrap.data0", if_b.data_o, 9'd255);
        step(1, 1, 9'h100);
        chk("wrap.valid1", {8'd0, if_b.valid_o}, 9'd1);
        chk("wrap.data1", if_b.data_o, 9'd1);

        // Differential delay M=2 on instance c: 10,20,30,40 -> 10,20,20,20
        step(0, 0, 0);
        step(1, 1, 9'd10);
        chk("dd.data0", if_c.data_o, 9'd10);
        step(1, 1, 9'd20);
        chk("dd.data1", if_c.data_o, 9'd20);
        step(1, 1, 9'd30);
        chk("dd.data2", if_c.data_o, 9'd20);
        step(1, 1, 9'd40);
        chk("dd.data3", if_c.data_o, 9'd20);
        chk("dd.valid3", {8'd0, if_c.valid_o}, 9'd1);

        // Mid-group reset, then randomized traffic with occasional resets
        step(1, 1, 9'd3);
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                do_reset();
            end else begin
                step(($urandom_range(0, 31) != 0), $urandom_range(0, 1) == 1,
                     9'($urandom_range(0, 511)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
